// File: rtl/pwl_exp_eval.sv
// Piecewise-linear exp(x) evaluator: y = k*x + b per lane, clamped to [0, 1.0], plus a per-frame sum of all y.
// Latency: y_valid MEM_LAT+2 cycles after x_valid; sum_valid one cycle after the y_last beat.
// No backpressure: a beat is accepted every cycle and nothing in the pipeline stalls.
module pwl_exp_eval #(
  parameter int LANES      = 10,
  parameter int XW         = 16,
  parameter int DW         = 16,
  parameter int FRAC_SHIFT = 12,
  parameter int MEM_LAT    = 1,
  parameter int SUMW       = 24
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [LANES*XW-1:0]   x_in,
  input  logic                  x_valid,
  input  logic                  x_last,
  input  logic [LANES*DW-1:0]   k_in,
  input  logic [LANES*DW-1:0]   b_in,
  output logic [LANES*DW-1:0]   y_out,
  output logic                  y_valid,
  output logic                  y_last,
  output logic [SUMW-1:0]       sum_out,
  output logic                  sum_valid
);

  localparam int PW  = XW + DW;  // full signed product width
  localparam int BSW = DW + 4;   // one beat's lane sum
  // 1.0 in Q1.15, held at the stage-A sum width for the upper clamp compare
  localparam logic signed [PW:0] ONE = (PW+1)'(1) << (DW - 1);

  // ---------------- alignment delay line ----------------
  logic [MEM_LAT-1:0][LANES*XW-1:0] xd;
  logic [MEM_LAT-1:0]               vd;
  logic [MEM_LAT-1:0]               ld;

  // x data follows the coefficient memory latency; data needs no reset
  always_ff @(posedge aclk) begin
    xd[0] <= x_in;
    for (int i = 1; i < MEM_LAT; i++) xd[i] <= xd[i-1];
  end

  // valid/last follow the same path; reset drops every in-flight beat
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      vd <= '0;
      ld <= '0;
    end else begin
      vd[0] <= x_valid;
      ld[0] <= x_valid & x_last;
      for (int i = 1; i < MEM_LAT; i++) begin
        vd[i] <= vd[i-1];
        ld[i] <= ld[i-1];
      end
    end
  end

  // ---------------- stage M: k*x ----------------
  logic signed [PW-1:0] k_ext [LANES];
  logic signed [PW-1:0] x_ext [LANES];
  logic signed [PW-1:0] prod  [LANES];
  logic [LANES*DW-1:0]  bm;
  logic                 m_vld;
  logic                 m_last;

  // sign-extend both operands so the truncated product is the exact signed result
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      k_ext[i] = PW'($signed(k_in[i*DW +: DW]));
      x_ext[i] = PW'($signed(xd[MEM_LAT-1][i*XW +: XW]));
    end
  end

  // product and intercept registered together so b stays aligned with k*x
  always_ff @(posedge aclk) begin
    for (int i = 0; i < LANES; i++) prod[i] <= k_ext[i] * x_ext[i];
    bm <= b_in;
  end

  // stage M control
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_vld  <= 1'b0;
      m_last <= 1'b0;
    end else begin
      m_vld  <= vd[MEM_LAT-1];
      m_last <= ld[MEM_LAT-1];
    end
  end

  // ---------------- stage A: shift, add b, clamp ----------------
  logic signed [PW-1:0] p_sh;
  logic signed [PW:0]   s;
  logic [LANES*DW-1:0]  y_nx;

  // arithmetic shift floors toward -inf; negative results clamp to 0, above 1.0 to 1.0
  always_comb begin
    y_nx = '0;
    p_sh = '0;
    s    = '0;
    for (int i = 0; i < LANES; i++) begin
      p_sh = prod[i] >>> FRAC_SHIFT;
      s    = (PW+1)'(p_sh) + (PW+1)'($signed(bm[i*DW +: DW]));
      if (s[PW])       y_nx[i*DW +: DW] = '0;
      else if (s > ONE) y_nx[i*DW +: DW] = ONE[DW-1:0];
      else             y_nx[i*DW +: DW] = s[DW-1:0];
    end
  end

  // y register; holds its last value while no beat is present
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      y_out   <= '0;
      y_valid <= 1'b0;
      y_last  <= 1'b0;
    end else begin
      y_valid <= m_vld;
      y_last  <= m_vld & m_last;
      if (m_vld) y_out <= y_nx;
    end
  end

  // ---------------- stage S: frame accumulator ----------------
  logic [BSW-1:0]  beat_sum;
  logic [SUMW:0]   acc_nx;
  logic [SUMW-1:0] acc_sat;
  logic [SUMW-1:0] acc;

  // lane sum of the current y beat and the saturated running total
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) beat_sum = beat_sum + BSW'(y_out[i*DW +: DW]);
    acc_nx  = (SUMW+1)'(acc) + (SUMW+1)'(beat_sum);
    acc_sat = acc_nx[SUMW] ? '1 : acc_nx[SUMW-1:0];
  end

  // the last beat publishes the total and restarts the next frame from zero
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc       <= '0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (y_valid) begin
        if (y_last) begin
          sum_out   <= acc_sat;
          sum_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwl_exp_eval.sv
// Directed bench for pwl_exp_eval: table of single-beat frames plus frame-sum and reset sequences.
// Latency: y expected 3 cycles and sum 4 cycles after x_valid (MEM_LAT=1).
// No backpressure: stimulus drives k/b one cycle after the matching x, as the memories would.
module tb_pwl_exp_eval;
  localparam int LANES = 10;
  localparam int XW    = 16;
  localparam int DW    = 16;
  localparam int SUMW  = 24;
  localparam int W     = LANES * DW;

  logic                aclk = 1'b0;
  logic                aresetn;
  logic [LANES*XW-1:0] x_in;
  logic                x_valid;
  logic                x_last;
  logic [W-1:0]        k_in;
  logic [W-1:0]        b_in;
  logic [W-1:0]        y_out;
  logic                y_valid;
  logic                y_last;
  logic [SUMW-1:0]     sum_out;
  logic                sum_valid;

  pwl_exp_eval #(
    .LANES(LANES), .XW(XW), .DW(DW), .FRAC_SHIFT(12), .MEM_LAT(1), .SUMW(SUMW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .x_in(x_in), .x_valid(x_valid), .x_last(x_last),
    .k_in(k_in), .b_in(b_in),
    .y_out(y_out), .y_valid(y_valid), .y_last(y_last),
    .sum_out(sum_out), .sum_valid(sum_valid)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] k;
    logic [W-1:0] b;
    logic [W-1:0] y;
  } vec_t;

  vec_t         vecs [6];
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  logic [W-1:0] pk;
  logic [W-1:0] pb;

  int              yq_cyc [$];
  logic [W-1:0]    yq_val [$];
  logic            yq_last [$];
  int              sq_cyc [$];
  logic [SUMW-1:0] sq_val [$];

  // cycle counter and output monitor, sampled on the falling edge
  always @(posedge aclk) cyc <= cyc + 1;
  always @(negedge aclk) begin
    if (y_valid) begin
      yq_cyc.push_back(cyc);
      yq_val.push_back(y_out);
      yq_last.push_back(y_last);
    end
    if (sum_valid) begin
      sq_cyc.push_back(cyc);
      sq_val.push_back(sum_out);
    end
  end

  function automatic logic [W-1:0] rep(input logic [15:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++) r[i*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [SUMW-1:0] lsum(input logic [W-1:0] y);
    logic [SUMW-1:0] t;
    t = '0;
    for (int i = 0; i < LANES; i++) t = t + SUMW'(y[i*DW +: DW]);
    return t;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one cycle of stimulus: x now, k/b for the beat driven one cycle earlier
  task automatic drive(input logic [W-1:0] x, input logic v, input logic l,
                       input logic [W-1:0] k, input logic [W-1:0] b, output int c);
    c       = cyc;
    x_in    = x;
    x_valid = v;
    x_last  = l;
    k_in    = pk;
    b_in    = pb;
    pk      = k;
    pb      = b;
    @(posedge aclk);
    #1;
  endtask

  task automatic idle(input int n);
    int c;
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, '0, '0, c);
  endtask

  task automatic clear_q();
    yq_cyc.delete();
    yq_val.delete();
    yq_last.delete();
    sq_cyc.delete();
    sq_val.delete();
  endtask

  initial begin
    int   c;
    int   c2;
    vec_t v;

    aresetn = 1'b0;
    x_in = '0; x_valid = 1'b0; x_last = 1'b0;
    k_in = '0; b_in = '0; pk = '0; pb = '0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_y_out",     y_out,              W'(0));
    chk("rst_y_valid",   W'(y_valid),        W'(0));
    chk("rst_y_last",    W'(y_last),         W'(0));
    chk("rst_sum_out",   W'(sum_out),        W'(0));
    chk("rst_sum_valid", W'(sum_valid),      W'(0));
    aresetn = 1'b1;
    idle(2);

    // basic: lane0 -1.0*0.5+0.5 = 0, lane1 x=0 gives b=0x7FFF, others y=b=0x2000
    v.x = rep(16'h0000); v.x[15:0] = 16'hF000;
    v.k = rep(16'h4000);
    v.b = rep(16'h2000); v.b[15:0] = 16'h4000; v.b[31:16] = 16'h7FFF;
    v.y = rep(16'h2000); v.y[15:0] = 16'h0000; v.y[31:16] = 16'h7FFF;
    vecs[0] = v;
    // upper clamp: (-1.0)*(-8.0) -> 262144
    vecs[1] = '{rep(16'h8000), rep(16'h8000), rep(16'h0000), rep(16'h8000)};
    // lower clamp: -131072 + 4096 -> negative
    vecs[2] = '{rep(16'h8000), rep(16'h4000), rep(16'h1000), rep(16'h0000)};
    // mid value: 0.25*(-2.0) + 0.75 = 0.25
    vecs[3] = '{rep(16'hE000), rep(16'h2000), rep(16'h6000), rep(16'h2000)};
    // floor: -1 >>> 12 = -1, so 0x100 - 1
    vecs[4] = '{rep(16'hFFFF), rep(16'h0001), rep(16'h0100), rep(16'h00FF)};
    // clamp edge: p>>>12 = 128; 0x7F80 -> exactly 1.0, 0x7F81 -> clamped, 0x7F7F -> 0x7FFF
    v.x = rep(16'hFFF0);
    v.k = rep(16'h8000);
    v.b = rep(16'h7F80); v.b[31:16] = 16'h7F81; v.b[47:32] = 16'h7F7F;
    v.y = rep(16'h8000); v.y[47:32] = 16'h7FFF;
    vecs[5] = v;

    for (int i = 0; i < 6; i++) begin
      clear_q();
      drive(vecs[i].x, 1'b1, 1'b1, vecs[i].k, vecs[i].b, c);
      idle(6);
      chk($sformatf("v%0d_ycount", i), W'(yq_cyc.size()), W'(1));
      if (yq_cyc.size() > 0) begin
        chk($sformatf("v%0d_ylat", i),  W'(yq_cyc[0] - c), W'(3));
        chk($sformatf("v%0d_y", i),     yq_val[0],         vecs[i].y);
        chk($sformatf("v%0d_ylast", i), W'(yq_last[0]),    W'(1));
      end
      chk($sformatf("v%0d_yhold", i), y_out, vecs[i].y);
      chk($sformatf("v%0d_scount", i), W'(sq_cyc.size()), W'(1));
      if (sq_cyc.size() > 0) begin
        chk($sformatf("v%0d_slat", i), W'(sq_cyc[0] - c), W'(4));
        chk($sformatf("v%0d_sum", i),  W'(sq_val[0]),     W'(lsum(vecs[i].y)));
      end
    end

    // three-beat frame, y=0x1000 on every lane
    clear_q();
    drive(rep(16'h0000), 1'b1, 1'b0, rep(16'h0000), rep(16'h1000), c);
    drive(rep(16'h0000), 1'b1, 1'b0, rep(16'h0000), rep(16'h1000), c);
    drive(rep(16'h0000), 1'b1, 1'b1, rep(16'h0000), rep(16'h1000), c);
    idle(6);
    chk("f3_ycount", W'(yq_cyc.size()), W'(3));
    chk("f3_scount", W'(sq_cyc.size()), W'(1));
    if (sq_cyc.size() > 0) begin
      chk("f3_sum",  W'(sq_val[0]),     W'(24'h01E000));
      chk("f3_slat", W'(sq_cyc[0] - c), W'(4));
    end

    // back-to-back frames: A = 2 beats of 0x0100, B = 1 beat of 0x0200
    clear_q();
    drive(rep(16'h0000), 1'b1, 1'b0, rep(16'h0000), rep(16'h0100), c);
    drive(rep(16'h0000), 1'b1, 1'b1, rep(16'h0000), rep(16'h0100), c);
    drive(rep(16'h0000), 1'b1, 1'b1, rep(16'h0000), rep(16'h0200), c2);
    idle(6);
    chk("b2b_scount", W'(sq_cyc.size()), W'(2));
    if (sq_cyc.size() > 1) begin
      chk("b2b_sumA",  W'(sq_val[0]),      W'(24'h001400));
      chk("b2b_latA",  W'(sq_cyc[0] - c),  W'(4));
      chk("b2b_sumB",  W'(sq_val[1]),      W'(24'h001400));
      chk("b2b_latB",  W'(sq_cyc[1] - c2), W'(4));
    end

    // reset with two beats in flight
    clear_q();
    drive(rep(16'h0000), 1'b1, 1'b0, rep(16'h0000), rep(16'h0300), c);
    drive(rep(16'h0000), 1'b1, 1'b0, rep(16'h0000), rep(16'h0300), c);
    aresetn = 1'b0;
    idle(1);
    chk("mrst_y_out",     y_out,         W'(0));
    chk("mrst_y_valid",   W'(y_valid),   W'(0));
    chk("mrst_sum_out",   W'(sum_out),   W'(0));
    chk("mrst_sum_valid", W'(sum_valid), W'(0));
    aresetn = 1'b1;
    idle(6);
    chk("mrst_ycount", W'(yq_cyc.size()), W'(0));
    chk("mrst_scount", W'(sq_cyc.size()), W'(0));

    // fresh single-beat frame after reset, y=0x0001 on every lane
    clear_q();
    drive(rep(16'h0000), 1'b1, 1'b1, rep(16'h0000), rep(16'h0001), c);
    idle(6);
    chk("post_scount", W'(sq_cyc.size()), W'(1));
    if (sq_cyc.size() > 0) begin
      chk("post_sum",  W'(sq_val[0]),     W'(24'h00000A));
      chk("post_slat", W'(sq_cyc[0] - c), W'(4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
